// File: rtl/simplez_pkg.sv
// Shared constants and loader state encoding for the Simplez program loader.
package simplez_pkg;

   localparam logic [7:0] LOAD_CMD = 8'h4C;

   localparam int AW = 9;
   localparam int DW = 12;
   localparam logic [AW-1:0] RAM_TOP = 9'h1F7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT_H,
      ST_CNT_L,
      ST_DATA_H,
      ST_DATA_L,
      ST_CSUM
   } ld_state_e;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on every received byte and pulses expire_o for one
// cycle once TIMEOUT-1 idle cycles have followed the last reload.
module loader_timeout #(
   parameter int TIMEOUT = 2400000
) (
   input  logic clk,
   input  logic rstn,
   input  logic reload_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (reload_i) begin
         cnt_d = CW'(TIMEOUT - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry in the cycle where an error would be registered; a byte in that same cycle wins upstream.
   assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/simplez_loader.sv
// Serial loader: decodes 'L' CNT_H CNT_L {HI LO}*N CSUM frames from uart_rx and writes RAM words.
// Word write is registered one cycle after its LO byte; no backpressure, bytes arrive as strobes.
module simplez_loader
   import simplez_pkg::*;
#(
   parameter int TIMEOUT   = 2400000,
   parameter bit AUTOSTART = 1'b1,
   parameter int MAX_WORDS = int'(RAM_TOP) + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          rx_rcv,
   input  logic [7:0]    rx_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          cpu_rstn,
   output logic          loading,
   output logic          load_ok,
   output logic          load_err
);

   localparam logic [AW-1:0] MAXW = AW'(MAX_WORDS);

   ld_state_e     state_q, state_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_din_q, mem_din_d;
   logic          cpu_rstn_q, cpu_rstn_d;
   logic          loading_q, loading_d;
   logic          load_ok_q, load_ok_d;
   logic          load_err_q, load_err_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] nwords_q, nwords_d;
   logic          cnt_hi_q, cnt_hi_d;
   logic [3:0]    nib_q, nib_d;
   logic [7:0]    sum_q, sum_d;
   logic [AW-1:0] n_cand;
   logic          err_c;
   logic          tmo_expire;

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .rstn     (rstn),
      .reload_i (rx_rcv),
      .expire_o (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      cpu_rstn_d = cpu_rstn_q;
      loading_d  = loading_q;
      load_ok_d  = load_ok_q;
      load_err_d = load_err_q;
      idx_d      = idx_q;
      nwords_d   = nwords_q;
      cnt_hi_d   = cnt_hi_q;
      nib_d      = nib_q;
      sum_d      = sum_q;
      n_cand     = {cnt_hi_q, rx_data};
      err_c      = 1'b0;

      if (state_q != ST_IDLE && tmo_expire && !rx_rcv) begin
         err_c = 1'b1;
      end

      if (rx_rcv) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_data == LOAD_CMD) begin
                  state_d    = ST_CNT_H;
                  cpu_rstn_d = 1'b0;
                  loading_d  = 1'b1;
                  load_ok_d  = 1'b0;
                  load_err_d = 1'b0;
                  idx_d      = '0;
                  sum_d      = '0;
               end
            end
            ST_CNT_H: begin
               if (rx_data[7:1] != 7'd0) begin
                  err_c = 1'b1;
               end else begin
                  cnt_hi_d = rx_data[0];
                  state_d  = ST_CNT_L;
               end
            end
            ST_CNT_L: begin
               if (n_cand == '0 || n_cand > MAXW) begin
                  err_c = 1'b1;
               end else begin
                  nwords_d = n_cand;
                  state_d  = ST_DATA_H;
               end
            end
            ST_DATA_H: begin
               if (rx_data[7:4] != 4'd0) begin
                  err_c = 1'b1;
               end else begin
                  nib_d   = rx_data[3:0];
                  sum_d   = sum_q + rx_data;
                  state_d = ST_DATA_L;
               end
            end
            ST_DATA_L: begin
               mem_we_d   = 1'b1;
               mem_addr_d = idx_q;
               mem_din_d  = {nib_q, rx_data};
               idx_d      = idx_q + 1'b1;
               sum_d      = sum_q + rx_data;
               state_d    = (idx_q == nwords_q - 1'b1) ? ST_CSUM : ST_DATA_H;
            end
            ST_CSUM: begin
               if (rx_data == sum_q) begin
                  load_ok_d  = 1'b1;
                  loading_d  = 1'b0;
                  cpu_rstn_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  err_c = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Abort keeps the core in reset; partially written words stay in RAM.
      if (err_c) begin
         state_d    = ST_IDLE;
         load_err_d = 1'b1;
         loading_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         cpu_rstn_q <= AUTOSTART;
         loading_q  <= 1'b0;
         load_ok_q  <= 1'b0;
         load_err_q <= 1'b0;
         idx_q      <= '0;
         nwords_q   <= '0;
         cnt_hi_q   <= 1'b0;
         nib_q      <= '0;
         sum_q      <= '0;
      end else begin
         state_q    <= state_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         cpu_rstn_q <= cpu_rstn_d;
         loading_q  <= loading_d;
         load_ok_q  <= load_ok_d;
         load_err_q <= load_err_d;
         idx_q      <= idx_d;
         nwords_q   <= nwords_d;
         cnt_hi_q   <= cnt_hi_d;
         nib_q      <= nib_d;
         sum_q      <= sum_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign cpu_rstn = cpu_rstn_q;
   assign loading  = loading_q;
   assign load_ok  = load_ok_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_simplez_loader.sv
// Bench for simplez_loader: directed and random frames checked against a frame-level model.
module tb_simplez_loader;

   logic        clk;
   logic        rstn;
   logic        rx_rcv;
   logic [7:0]  rx_data;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [11:0] mem_din;
   logic        cpu_rstn;
   logic        loading;
   logic        load_ok;
   logic        load_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  frm[$];
   logic [20:0] wr_q[$];
   logic [20:0] exp_wr[$];
   logic        exp_ok;
   logic        exp_err;

   simplez_loader #(
      .TIMEOUT   (100),
      .AUTOSTART (1'b1)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rx_rcv   (rx_rcv),
      .rx_data  (rx_data),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .cpu_rstn (cpu_rstn),
      .loading  (loading),
      .load_ok  (load_ok),
      .load_err (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_din});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe one byte in the current cycle; returns just after the capturing edge.
   task automatic send_byte(input logic [7:0] b);
      rx_rcv  = 1'b1;
      rx_data = b;
      tick();
      rx_rcv  = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_frame(input int maxgap);
      foreach (frm[i]) begin
         send_byte(frm[i]);
         repeat ($urandom_range(0, maxgap)) tick();
      end
      repeat (2) tick();
   endtask

   // Frame-level reference: what a whole byte sequence should write and report.
   task automatic model();
      int n;
      int sum;
      logic [7:0] hi, lo;
      exp_wr.delete();
      exp_ok  = 1'b0;
      exp_err = 1'b0;
      if (frm[1][7:1] != 7'd0) begin
         exp_err = 1'b1;
         return;
      end
      n = int'(frm[1][0]) * 256 + int'(frm[2]);
      if (n == 0 || n > 504) begin
         exp_err = 1'b1;
         return;
      end
      sum = 0;
      for (int i = 0; i < n; i++) begin
         hi = frm[3 + 2*i];
         if (hi[7:4] != 4'd0) begin
            exp_err = 1'b1;
            return;
         end
         lo = frm[4 + 2*i];
         sum = sum + int'(hi) + int'(lo);
         exp_wr.push_back({9'(i), hi[3:0], lo});
      end
      exp_ok  = (int'(frm[3 + 2*n]) == (sum % 256));
      exp_err = !exp_ok;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (cpu_rstn !== 1'b1) begin n_fail++; $display("FAIL reset cpu_rstn got %b exp 1", cpu_rstn); end
      n_checks++; if ({loading, load_ok, load_err} !== 3'b000) begin n_fail++; $display("FAIL reset flags got %b exp 000", {loading, load_ok, load_err}); end
      n_checks++; if ({mem_we, mem_addr, mem_din} !== 22'd0) begin n_fail++; $display("FAIL reset mem got %b/%h/%h exp 0/0/0", mem_we, mem_addr, mem_din); end
   endtask

   task automatic test_nominal();
      logic [7:0] f [8];
      f = '{8'h4C, 8'h00, 8'h02, 8'h02, 8'h05, 8'h0E, 8'h00, 8'h15};
      wr_q.delete();
      send_byte(f[0]);
      n_checks++; if ({cpu_rstn, loading} !== 2'b01) begin n_fail++; $display("FAIL nominal start cpu_rstn/loading got %b exp 01", {cpu_rstn, loading}); end
      for (int i = 1; i < 5; i++) send_byte(f[i]);
      n_checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 9'd0, 12'h205}) begin n_fail++; $display("FAIL nominal first write got %b/%h/%h exp 1/000/205", mem_we, mem_addr, mem_din); end
      for (int i = 5; i < 8; i++) send_byte(f[i]);
      n_checks++; if ({load_ok, load_err, cpu_rstn, loading} !== 4'b1010) begin n_fail++; $display("FAIL nominal done ok/err/cpu_rstn/loading got %b exp 1010", {load_ok, load_err, cpu_rstn, loading}); end
      tick();
      n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL nominal write count got %0d exp 2", wr_q.size()); end
      else begin
         n_checks++; if (wr_q[1] !== {9'd1, 12'hE00}) begin n_fail++; $display("FAIL nominal second write got %h exp %h", wr_q[1], {9'd1, 12'hE00}); end
      end
   endtask

   task automatic test_bad_csum();
      logic [7:0] f [8];
      f = '{8'h4C, 8'h00, 8'h02, 8'h02, 8'h05, 8'h0E, 8'h00, 8'h16};
      frm.delete();
      foreach (f[i]) frm.push_back(f[i]);
      model();
      wr_q.delete();
      send_frame(0);
      n_checks++; if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL bad_csum write count got %0d exp %0d", wr_q.size(), exp_wr.size()); end
      else foreach (exp_wr[i]) begin
         n_checks++; if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL bad_csum write %0d got %h exp %h", i, wr_q[i], exp_wr[i]); end
      end
      n_checks++; if ({load_ok, load_err, cpu_rstn, loading} !== {exp_ok, exp_err, exp_ok, 1'b0}) begin n_fail++; $display("FAIL bad_csum flags got %b exp %b", {load_ok, load_err, cpu_rstn, loading}, {exp_ok, exp_err, exp_ok, 1'b0}); end
   endtask

   task automatic test_count_errors();
      logic [7:0] c [3][3];
      c = '{'{8'h4C, 8'h00, 8'h00}, '{8'h4C, 8'h01, 8'hF9}, '{8'h4C, 8'h02, 8'h00}};
      for (int k = 0; k < 3; k++) begin
         frm.delete();
         for (int j = 0; j < ((k == 2) ? 2 : 3); j++) frm.push_back(c[k][j]);
         model();
         wr_q.delete();
         send_byte(frm[0]);
         send_byte(frm[1]);
         if (k == 2) begin
            n_checks++; if ({load_err, loading} !== 2'b10) begin n_fail++; $display("FAIL cnt_h immediate err/loading got %b exp 10", {load_err, loading}); end
         end else send_byte(frm[2]);
         repeat (2) tick();
         n_checks++; if ({wr_q.size() == 0, load_err, load_ok, cpu_rstn} !== {1'b1, exp_err, exp_ok, exp_ok}) begin n_fail++; $display("FAIL count case %0d nowrite/err/ok/cpu_rstn got %b exp %b", k, {wr_q.size() == 0, load_err, load_ok, cpu_rstn}, {1'b1, exp_err, exp_ok, exp_ok}); end
      end
   endtask

   task automatic test_timeout();
      wr_q.delete();
      send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
      repeat (98) tick();
      n_checks++; if ({load_err, loading} !== 2'b01) begin n_fail++; $display("FAIL timeout early err/loading got %b exp 01", {load_err, loading}); end
      tick();
      n_checks++; if ({load_err, loading, cpu_rstn} !== 3'b100) begin n_fail++; $display("FAIL timeout expiry err/loading/cpu_rstn got %b exp 100", {load_err, loading, cpu_rstn}); end
      send_byte(8'h02);
      tick();
      n_checks++; if ({loading, wr_q.size() == 0} !== 2'b01) begin n_fail++; $display("FAIL timeout idle loading/nowrite got %b exp 01", {loading, wr_q.size() == 0}); end
      send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
      repeat (98) tick();
      send_byte(8'h05);
      n_checks++; if ({load_err, mem_we, mem_din} !== {1'b0, 1'b1, 12'h205}) begin n_fail++; $display("FAIL timeout last-cycle byte err/we/din got %b/%b/%h exp 0/1/205", load_err, mem_we, mem_din); end
      send_byte(8'h07);
      n_checks++; if ({load_ok, load_err, cpu_rstn} !== 3'b101) begin n_fail++; $display("FAIL timeout recovered ok/err/cpu_rstn got %b exp 101", {load_ok, load_err, cpu_rstn}); end
   endtask

   task automatic test_autostart();
      do_reset();
      send_byte(8'h41); send_byte(8'h00);
      n_checks++; if ({cpu_rstn, loading} !== 2'b10) begin n_fail++; $display("FAIL autostart non-L cpu_rstn/loading got %b exp 10", {cpu_rstn, loading}); end
      send_byte(8'h4C);
      n_checks++; if ({cpu_rstn, loading} !== 2'b01) begin n_fail++; $display("FAIL autostart L cpu_rstn/loading got %b exp 01", {cpu_rstn, loading}); end
      send_byte(8'h00); send_byte(8'h01);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      n_checks++; if ({cpu_rstn, loading, load_err, load_ok} !== 4'b1000) begin n_fail++; $display("FAIL midframe reset cpu_rstn/loading/err/ok got %b exp 1000", {cpu_rstn, loading, load_err, load_ok}); end
      send_byte(8'h02); send_byte(8'h05);
      tick();
      n_checks++; if ({loading, mem_we} !== 2'b00) begin n_fail++; $display("FAIL midframe reset idle loading/we got %b exp 00", {loading, mem_we}); end
   endtask

   task automatic test_random();
      int n, kind, bad, sum;
      logic [7:0] hi, lo;
      for (int it = 0; it < 10; it++) begin
         n    = $urandom_range(1, 8);
         kind = $urandom_range(0, 2);
         bad  = $urandom_range(0, n - 1);
         frm.delete();
         frm.push_back(8'h4C);
         frm.push_back({7'd0, n[8]});
         frm.push_back(n[7:0]);
         sum = 0;
         for (int i = 0; i < n; i++) begin
            hi = {4'h0, 4'($urandom)};
            if (kind == 2 && i == bad) hi[7:4] = 4'($urandom_range(1, 15));
            frm.push_back(hi);
            if (kind == 2 && i == bad) break;
            lo = 8'($urandom);
            frm.push_back(lo);
            sum = sum + int'(hi) + int'(lo);
         end
         if (kind != 2) frm.push_back(8'(sum + ((kind == 1) ? 1 : 0)));
         model();
         wr_q.delete();
         send_frame(3);
         n_checks++; if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL random %0d write count got %0d exp %0d", it, wr_q.size(), exp_wr.size()); end
         else foreach (exp_wr[i]) begin
            n_checks++; if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL random %0d write %0d got %h exp %h", it, i, wr_q[i], exp_wr[i]); end
         end
         n_checks++; if ({load_ok, load_err, cpu_rstn, loading} !== {exp_ok, exp_err, exp_ok, 1'b0}) begin n_fail++; $display("FAIL random %0d flags got %b exp %b", it, {load_ok, load_err, cpu_rstn, loading}, {exp_ok, exp_err, exp_ok, 1'b0}); end
      end
   endtask

   task automatic test_full();
      int sum;
      frm.delete();
      frm.push_back(8'h4C); frm.push_back(8'h01); frm.push_back(8'hF8);
      sum = 0;
      for (int i = 0; i < 504; i++) begin
         frm.push_back(8'(i / 256));
         frm.push_back(8'(i % 256));
         sum = sum + i / 256 + i % 256;
      end
      frm.push_back(8'(sum % 256));
      model();
      wr_q.delete();
      send_frame(0);
      n_checks++; if (wr_q.size() != 504) begin n_fail++; $display("FAIL full write count got %0d exp 504", wr_q.size()); end
      else foreach (exp_wr[i]) begin
         n_checks++; if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL full write %0d got %h exp %h", i, wr_q[i], exp_wr[i]); end
      end
      n_checks++; if ({load_ok, load_err, cpu_rstn} !== 3'b101) begin n_fail++; $display("FAIL full flags ok/err/cpu_rstn got %b exp 101", {load_ok, load_err, cpu_rstn}); end
   endtask

   initial begin
      rstn    = 1'b0;
      rx_rcv  = 1'b0;
      rx_data = 8'h00;
      test_reset();
      test_nominal();
      test_bad_csum();
      test_count_errors();
      test_timeout();
      test_autostart();
      test_random();
      test_full();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
